id_ex_stage: RTL

- ID/EX pipeline register plus EX-stage operand selection.
- Registers decoded operands and control from ID, applies EX/MEM and MEM/WB forwarding, generates the 4-bit ALU control code, and drives the ALU operand inputs directly.
- Detects load-use hazards for the hazard/stall logic upstream.

---
 rtl/id_ex_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-stage operand forwarding,
// ALU control decode and load-use hazard detection.
// Optional feature macro: ID_EX_PERF_EN adds the bubble_count output.
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          stall,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [3:0]    alu_control,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          load_use_hazard
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]   bubble_count
`endif
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    UPD_CAPTURE,
    UPD_HOLD,
    UPD_BUBBLE
  } upd_e;

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic [3:0]    alu_ctrl;
    logic [RW-1:0] dest;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
  } ex_regs_t;

  ex_regs_t ex_q, ex_d, bubble;
  upd_e     upd;
  logic [3:0] alu_ctrl_dec;
  logic [DW-1:0] fwd_a, fwd_b;

  // Bubble and reset share the same contents: no controls, cleared data, add.
  always_comb begin
    bubble          = '0;
    bubble.alu_ctrl = ALU_ADD;
  end

  // Update priority: flush > hold > stall > capture (rst handled in the flop).
  always_comb begin
    upd = UPD_CAPTURE;
    if (flush)      upd = UPD_BUBBLE;
    else if (hold)  upd = UPD_HOLD;
    else if (stall) upd = UPD_BUBBLE;
  end

  // ALU control decode from alu_op and funct.
  always_comb begin
    alu_ctrl_dec = ALU_ADD;
    unique case (id_alu_op)
      2'b00: alu_ctrl_dec = ALU_ADD;
      2'b01: alu_ctrl_dec = ALU_SUB;
      2'b11: alu_ctrl_dec = ALU_OR;
      default: begin
        case (id_funct)
          6'b100000: alu_ctrl_dec = ALU_ADD;
          6'b100010: alu_ctrl_dec = ALU_SUB;
          6'b100100: alu_ctrl_dec = ALU_AND;
          6'b100101: alu_ctrl_dec = ALU_OR;
          6'b101010: alu_ctrl_dec = ALU_SLT;
          default:   alu_ctrl_dec = ALU_NOP;
        endcase
      end
    endcase
  end

  // Next register contents.
  always_comb begin
    ex_d = ex_q;
    case (upd)
      UPD_BUBBLE: ex_d = bubble;
      UPD_HOLD:   ex_d = ex_q;
      default: begin
        ex_d.valid      = id_valid;
        ex_d.reg_write  = id_reg_write;
        ex_d.mem_read   = id_mem_read;
        ex_d.mem_write  = id_mem_write;
        ex_d.mem_to_reg = id_mem_to_reg;
        ex_d.alu_src    = id_alu_src;
        ex_d.alu_ctrl   = alu_ctrl_dec;
        ex_d.dest       = id_reg_dst ? id_rd : id_rt;
        ex_d.rs         = id_rs;
        ex_d.rt         = id_rt;
        ex_d.rs_data    = id_rs_data;
        ex_d.rt_data    = id_rt_data;
        ex_d.imm        = id_imm;
      end
    endcase
  end

  // ID/EX register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) ex_q <= bubble;
    else     ex_q <= ex_d;
  end

  // Operand forwarding: EX/MEM beats MEM/WB; register 0 never forwarded.
  always_comb begin
    fwd_a = ex_q.rs_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs)
      fwd_a = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs)
      fwd_a = memwb_result;
    fwd_b = ex_q.rt_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rt)
      fwd_b = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rt)
      fwd_b = memwb_result;
  end

  // Output drive and load-use hazard detection.
  always_comb begin
    alu_in1         = fwd_a;
    alu_in2         = ex_q.alu_src ? ex_q.imm : fwd_b;
    ex_store_data   = fwd_b;
    alu_control     = ex_q.alu_ctrl;
    ex_dest         = ex_q.dest;
    ex_valid        = ex_q.valid;
    ex_reg_write    = ex_q.reg_write;
    ex_mem_read     = ex_q.mem_read;
    ex_mem_write    = ex_q.mem_write;
    ex_mem_to_reg   = ex_q.mem_to_reg;
    load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && id_valid &&
                      ((ex_q.dest == id_rs) ||
                       ((ex_q.dest == id_rt) && (!id_alu_src || id_mem_write)));
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_count_q, bubble_count_d;

  // Count bubbles inserted by flush or stall; hold alone is not a bubble.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if ((upd == UPD_BUBBLE) && (bubble_count_q != '1))
      bubble_count_d = bubble_count_q + 32'd1;
  end

  // Bubble counter register.
  always_ff @(posedge clk) begin
    if (rst) bubble_count_q <= '0;
    else     bubble_count_q <= bubble_count_d;
  end

  assign bubble_count = bubble_count_q;
`endif

endmodule
